pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//   Sequences the 8-bit program_counter (PCL) and owns the PC high byte (PCH) to form a 16-bit fetch address.
//   Runs the reset-vector fetch, arbitrates jump/branch/fetch requests and drives exactly one PCL strobe per cycle.
//   Handles the 6502 branch page-cross fix-up cycle. Sits between instruction decode and the PCL register.
// PARAMETERS
//   RESET_VECTOR  16'hFFFC  address of vector low byte; high byte at RESET_VECTOR+1
//   PCH_RESET     8'h00     PCH value held during and after reset until the vector loads
// PORTS
//   clk            in   1   single system clock, rising edge
//   reset          in   1   synchronous, active-high reset
//   fetch_req      in   1   advance PC by one
//   branch_req     in   1   take relative branch
//   branch_offset  in   8   signed two's-complement branch displacement
//   jmp_req        in   1   absolute jump
//   jmp_target     in   16  jump destination
//   mem_data       in   8   memory read data (vector bytes), valid same cycle as addr
//   pcl            in   8   current PCL value from program_counter
//   pcl_carry      in   1   program_counter carry (PCL==FF and increment)
//   pc_increment   out  1   PCL increment strobe
//   pc_branch_load out  1   PCL branch-load strobe
//   pc_branch      out  8   PCL branch value
//   pc_jmp_load    out  1   PCL jump-load strobe
//   pc_jmp_addr    out  8   PCL jump value
//   pch            out  8   PC high byte
//   addr           out  16  fetch address: vector address in VEC states, else {pch,pcl}
//   ready          out  1   high only in RUN; requests accepted only when ready
// BEHAVIOUR
//   Reset: state<=VEC_LO, pch<=PCH_RESET, vec_lo<=0; all strobes 0, ready=0. Reset mid-operation aborts any state.
//   Strobes combinational from state/requests; at most one of increment/branch_load/jmp_load high per cycle.
//   FSM states: VEC_LO, VEC_HI, RUN, BR_FIX.
//   VEC_LO: addr=RESET_VECTOR; vec_lo<=mem_data; ->VEC_HI.
//   VEC_HI: addr=RESET_VECTOR+1; pc_jmp_load=1, pc_jmp_addr=vec_lo; pch<=mem_data; ->RUN.
//   RUN priority jmp_req > branch_req > fetch_req; losing requests dropped (not queued).
//     jmp: pc_jmp_load=1, pc_jmp_addr=jmp_target[7:0]; pch<=jmp_target[15:8]; stay RUN; 1-cycle latency.
//     branch: sum9 = {1'b0,pcl} + {1'b0,branch_offset}; pc_branch=sum9[7:0], pc_branch_load=1.
//       cross_up = !offset[7] & sum9[8]; cross_dn = offset[7] & !sum9[8].
//       no cross: stay RUN (1 cycle). cross: latch dir, ->BR_FIX.
//     fetch: pc_increment=1; if pcl_carry, pch<=pch+1 (mod 256; FF->00).
//     no request: all strobes 0, PCL/PCH hold.
//   BR_FIX: no strobes, ready=0; pch<=pch+1 (up) or pch-1 (down), mod 256; ->RUN. Branch total 2 cycles.
//   Offset 8'h00: no cross, PCL reloaded with same value. Offset 8'h80 = -128.
//   Full 16-bit wrap: {FF,FF} fetch -> {00,00}.
//   Requests while ready=0 ignored, no side effects.
// TESTING
//   Reset, mem_data FFFC=34, FFFD=12 -> addr FFFC then FFFD; pch=12, PCL=34, ready=1 on cycle 3.
//   pc=12FF, fetch_req 1 cycle -> pc_increment=1, pc=1300 next cycle; at FFFF -> 0000.
//   pc=1280, branch +10 -> pc_branch=90, 1 cycle, pch stays 12; pc=12F0, +20 -> PCL=10, BR_FIX, pc=1310, ready low 1 cycle.
//   pc=1205, branch F0 (-16) -> PCL=F5, BR_FIX, pc=11F5; offset 00 -> pc unchanged, ready stays high.
//   jmp_req+branch_req+fetch_req same cycle, target ABCD -> only pc_jmp_load, pc=ABCD; requests in BR_FIX ignored.
//   Reset asserted in BR_FIX or VEC_HI -> next cycle VEC_LO, pch=PCH_RESET, all strobes 0.

Source files
------------

// File: rtl/pc_sequencer.sv
// PC sequencer: runs the reset-vector fetch, arbitrates jump/branch/fetch requests
// into single-cycle PCL strobes and owns the PC high byte, including the page-cross fix-up.
module pc_sequencer #(
    parameter logic [15:0] RESET_VECTOR = 16'hFFFC,
    parameter logic [7:0]  PCH_RESET    = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic        branch_req,
    input  logic [7:0]  branch_offset,
    input  logic        jmp_req,
    input  logic [15:0] jmp_target,
    input  logic [7:0]  mem_data,
    input  logic [7:0]  pcl,
    input  logic        pcl_carry,
    output logic        pc_increment,
    output logic        pc_branch_load,
    output logic [7:0]  pc_branch,
    output logic        pc_jmp_load,
    output logic [7:0]  pc_jmp_addr,
    output logic [7:0]  pch,
    output logic [15:0] addr,
    output logic        ready
);

    typedef enum logic [1:0] {
        VEC_LO = 2'd0,
        VEC_HI = 2'd1,
        RUN    = 2'd2,
        BR_FIX = 2'd3
    } state_t;

    state_t      state_r;
    logic [7:0]  vec_lo_r;
    logic [7:0]  pch_r;
    logic        fix_up_r;
    logic [8:0]  sum9_s;
    logic        cross_up_s;
    logic        cross_dn_s;

    // The carry out of the 8-bit add, read against the offset sign, tells whether the page changes.
    assign sum9_s     = {1'b0, pcl} + {1'b0, branch_offset};
    assign cross_up_s = ~branch_offset[7] & sum9_s[8];
    assign cross_dn_s = branch_offset[7] & ~sum9_s[8];
    assign pch        = pch_r;

    // Strobe decode and fetch address; jump wins over branch, branch over fetch.
    always_comb begin
        pc_increment   = 1'b0;
        pc_branch_load = 1'b0;
        pc_branch      = 8'h00;
        pc_jmp_load    = 1'b0;
        pc_jmp_addr    = 8'h00;
        ready          = 1'b0;
        addr           = {pch_r, pcl};
        case (state_r)
            VEC_LO: begin
                addr = RESET_VECTOR;
            end
            VEC_HI: begin
                addr        = RESET_VECTOR + 16'd1;
                pc_jmp_load = 1'b1;
                pc_jmp_addr = vec_lo_r;
            end
            RUN: begin
                ready = 1'b1;
                if (jmp_req) begin
                    pc_jmp_load = 1'b1;
                    pc_jmp_addr = jmp_target[7:0];
                end else if (branch_req) begin
                    pc_branch_load = 1'b1;
                    pc_branch      = sum9_s[7:0];
                end else if (fetch_req) begin
                    pc_increment = 1'b1;
                end else begin
                    pc_increment = 1'b0;
                end
            end
            BR_FIX: begin
                ready = 1'b0;
            end
            default: begin
                addr = RESET_VECTOR;
            end
        endcase
    end

    // Sequencer state, latched vector low byte and PC high byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= VEC_LO;
            pch_r    <= PCH_RESET;
            vec_lo_r <= 8'h00;
            fix_up_r <= 1'b0;
        end else begin
            case (state_r)
                VEC_LO: begin
                    vec_lo_r <= mem_data;
                    state_r  <= VEC_HI;
                end
                VEC_HI: begin
                    pch_r   <= mem_data;
                    state_r <= RUN;
                end
                RUN: begin
                    if (jmp_req) begin
                        pch_r <= jmp_target[15:8];
                    end else if (branch_req) begin
                        if (cross_up_s || cross_dn_s) begin
                            fix_up_r <= cross_up_s;
                            state_r  <= BR_FIX;
                        end else begin
                            state_r <= RUN;
                        end
                    end else if (fetch_req && pcl_carry) begin
                        pch_r <= pch_r + 8'd1;
                    end else begin
                        state_r <= RUN;
                    end
                end
                BR_FIX: begin
                    if (fix_up_r) begin
                        pch_r <= pch_r + 8'd1;
                    end else begin
                        pch_r <= pch_r - 8'd1;
                    end
                    state_r <= RUN;
                end
                default: begin
                    state_r <= VEC_LO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: models the external PCL register and
// predicts the 16-bit PC with plain address arithmetic.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req;
    logic        branch_req;
    logic [7:0]  branch_offset;
    logic        jmp_req;
    logic [15:0] jmp_target;
    logic [7:0]  mem_data;
    logic [7:0]  pcl_q;
    logic        pcl_carry;
    logic        pc_increment;
    logic        pc_branch_load;
    logic [7:0]  pc_branch;
    logic        pc_jmp_load;
    logic [7:0]  pc_jmp_addr;
    logic [7:0]  pch;
    logic [15:0] addr;
    logic        ready;

    logic [7:0]  vec_lo_val;
    logic [7:0]  vec_hi_val;
    int          checks = 0;
    int          failures = 0;

    pc_sequencer #(.RESET_VECTOR(16'hFFFC), .PCH_RESET(8'h00)) dut (
        .clk(clk), .reset(reset), .fetch_req(fetch_req), .branch_req(branch_req),
        .branch_offset(branch_offset), .jmp_req(jmp_req), .jmp_target(jmp_target),
        .mem_data(mem_data), .pcl(pcl_q), .pcl_carry(pcl_carry),
        .pc_increment(pc_increment), .pc_branch_load(pc_branch_load), .pc_branch(pc_branch),
        .pc_jmp_load(pc_jmp_load), .pc_jmp_addr(pc_jmp_addr), .pch(pch), .addr(addr),
        .ready(ready)
    );

    always #5 clk = ~clk;

    // Memory returns the vector bytes at the vector addresses, filler elsewhere.
    assign mem_data  = (addr == 16'hFFFC) ? vec_lo_val :
                       (addr == 16'hFFFD) ? vec_hi_val : 8'hEE;
    assign pcl_carry = (pcl_q == 8'hFF) && pc_increment;

    // External program_counter PCL register.
    always @(posedge clk) begin
        if (pc_jmp_load)         pcl_q <= pc_jmp_addr;
        else if (pc_branch_load) pcl_q <= pc_branch;
        else if (pc_increment)   pcl_q <= pcl_q + 8'd1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        fetch_req = 1'b0; branch_req = 1'b0; jmp_req = 1'b0;
        branch_offset = 8'h00; jmp_target = 16'h0000;
    endtask

    task automatic do_jmp(input logic [15:0] t);
        jmp_req = 1'b1; jmp_target = t;
        tick();
        clear_req();
    endtask

    task automatic test_reset();
        reset = 1'b1; clear_req();
        vec_lo_val = 8'h34; vec_hi_val = 8'h12;
        tick(); tick();
        checks++;
        if (ready !== 1'b0 || addr !== 16'hFFFC || pch !== 8'h00 ||
            pc_jmp_load !== 1'b0 || pc_increment !== 1'b0 || pc_branch_load !== 1'b0) begin
            failures++;
            $display("FAIL reset_state ready=%b addr=%h pch=%h strobes=%b%b%b exp ready=0 addr=fffc pch=00 strobes=000",
                     ready, addr, pch, pc_increment, pc_branch_load, pc_jmp_load);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (addr !== 16'hFFFD || pc_jmp_load !== 1'b1 || pc_jmp_addr !== 8'h34 || ready !== 1'b0) begin
            failures++;
            $display("FAIL vec_hi addr=%h jl=%b ja=%h ready=%b exp fffd 1 34 0",
                     addr, pc_jmp_load, pc_jmp_addr, ready);
        end
        tick();
        checks++;
        if (ready !== 1'b1 || {pch, pcl_q} !== 16'h1234) begin
            failures++;
            $display("FAIL vec_done ready=%b pc=%h exp ready=1 pc=1234", ready, {pch, pcl_q});
        end
    endtask

    task automatic test_fetch();
        do_jmp(16'h12FF);
        fetch_req = 1'b1;
        #1;
        checks++;
        if (pc_increment !== 1'b1 || pc_jmp_load !== 1'b0 || pc_branch_load !== 1'b0) begin
            failures++;
            $display("FAIL fetch_strobe inc=%b bl=%b jl=%b exp 1 0 0", pc_increment, pc_branch_load, pc_jmp_load);
        end
        tick(); clear_req();
        checks++;
        if ({pch, pcl_q} !== 16'h1300) begin
            failures++;
            $display("FAIL fetch_page pc=%h exp 1300", {pch, pcl_q});
        end
        do_jmp(16'hFFFF);
        fetch_req = 1'b1;
        tick(); clear_req();
        checks++;
        if ({pch, pcl_q} !== 16'h0000) begin
            failures++;
            $display("FAIL fetch_wrap pc=%h exp 0000", {pch, pcl_q});
        end
    endtask

    task automatic test_branch();
        do_jmp(16'h1280);
        branch_req = 1'b1; branch_offset = 8'h10;
        #1;
        checks++;
        if (pc_branch_load !== 1'b1 || pc_branch !== 8'h90) begin
            failures++;
            $display("FAIL branch_nocross bl=%b pb=%h exp 1 90", pc_branch_load, pc_branch);
        end
        tick(); clear_req();
        checks++;
        if ({pch, pcl_q} !== 16'h1290 || ready !== 1'b1) begin
            failures++;
            $display("FAIL branch_nocross_pc pc=%h ready=%b exp 1290 1", {pch, pcl_q}, ready);
        end
        do_jmp(16'h12F0);
        branch_req = 1'b1; branch_offset = 8'h20;
        tick();
        jmp_req = 1'b1; fetch_req = 1'b1; jmp_target = 16'h5555;
        #1;
        checks++;
        if (ready !== 1'b0 || pcl_q !== 8'h10 || pch !== 8'h12 ||
            pc_increment !== 1'b0 || pc_branch_load !== 1'b0 || pc_jmp_load !== 1'b0) begin
            failures++;
            $display("FAIL br_fix_up ready=%b pc=%h strobes=%b%b%b exp 0 1210 000",
                     ready, {pch, pcl_q}, pc_increment, pc_branch_load, pc_jmp_load);
        end
        tick(); clear_req();
        checks++;
        if ({pch, pcl_q} !== 16'h1310 || ready !== 1'b1) begin
            failures++;
            $display("FAIL cross_up_pc pc=%h ready=%b exp 1310 1", {pch, pcl_q}, ready);
        end
        do_jmp(16'h1205);
        branch_req = 1'b1; branch_offset = 8'hF0;
        tick(); clear_req();
        checks++;
        if (pcl_q !== 8'hF5 || ready !== 1'b0) begin
            failures++;
            $display("FAIL cross_dn_mid pcl=%h ready=%b exp f5 0", pcl_q, ready);
        end
        tick();
        checks++;
        if ({pch, pcl_q} !== 16'h11F5) begin
            failures++;
            $display("FAIL cross_dn_pc pc=%h exp 11f5", {pch, pcl_q});
        end
        branch_req = 1'b1; branch_offset = 8'h00;
        tick(); clear_req();
        checks++;
        if ({pch, pcl_q} !== 16'h11F5 || ready !== 1'b1) begin
            failures++;
            $display("FAIL offset_zero pc=%h ready=%b exp 11f5 1", {pch, pcl_q}, ready);
        end
    endtask

    task automatic test_jmp_priority();
        jmp_req = 1'b1; branch_req = 1'b1; fetch_req = 1'b1;
        jmp_target = 16'hABCD; branch_offset = 8'h7F;
        #1;
        checks++;
        if (pc_jmp_load !== 1'b1 || pc_jmp_addr !== 8'hCD || pc_branch_load !== 1'b0 || pc_increment !== 1'b0) begin
            failures++;
            $display("FAIL jmp_priority jl=%b ja=%h bl=%b inc=%b exp 1 cd 0 0",
                     pc_jmp_load, pc_jmp_addr, pc_branch_load, pc_increment);
        end
        tick(); clear_req();
        checks++;
        if ({pch, pcl_q} !== 16'hABCD) begin
            failures++;
            $display("FAIL jmp_pc pc=%h exp abcd", {pch, pcl_q});
        end
    endtask

    task automatic test_reset_mid();
        do_jmp(16'h12F0);
        branch_req = 1'b1; branch_offset = 8'h20;
        tick(); clear_req();
        reset = 1'b1;
        tick();
        #1;
        checks++;
        if (addr !== 16'hFFFC || pch !== 8'h00 || ready !== 1'b0 ||
            pc_increment !== 1'b0 || pc_branch_load !== 1'b0 || pc_jmp_load !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_brfix addr=%h pch=%h ready=%b exp fffc 00 0", addr, pch, ready);
        end
        reset = 1'b0;
        vec_lo_val = 8'($urandom_range(0, 255)); vec_hi_val = 8'($urandom_range(0, 255));
        tick();
        reset = 1'b1;
        tick();
        #1;
        checks++;
        if (addr !== 16'hFFFC || pch !== 8'h00 || pc_jmp_load !== 1'b0 || ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_vechi addr=%h pch=%h jl=%b exp fffc 00 0", addr, pch, pc_jmp_load);
        end
        reset = 1'b0;
        tick(); tick();
        checks++;
        if ({pch, pcl_q} !== {vec_hi_val, vec_lo_val} || ready !== 1'b1) begin
            failures++;
            $display("FAIL revector pc=%h ready=%b exp %h 1", {pch, pcl_q}, ready, {vec_hi_val, vec_lo_val});
        end
    endtask

    task automatic test_random();
        logic [15:0] pc_m;
        logic [15:0] nxt;
        logic [15:0] fix_target;
        logic        pending;
        pending = 1'b0;
        fix_target = 16'h0000;
        pc_m = {pch, pcl_q};
        for (int i = 0; i < 500; i++) begin
            jmp_req       = ($urandom_range(0, 9) == 0);
            branch_req    = ($urandom_range(0, 3) == 0);
            fetch_req     = ($urandom_range(0, 1) == 1);
            branch_offset = 8'($urandom_range(0, 255));
            jmp_target    = 16'($urandom_range(0, 65535));
            #1;
            checks++;
            if (ready !== !pending ||
                (int'(pc_increment) + int'(pc_branch_load) + int'(pc_jmp_load)) > 1) begin
                failures++;
                $display("FAIL rand_ready it=%0d ready=%b exp %b strobes=%b%b%b",
                         i, ready, !pending, pc_increment, pc_branch_load, pc_jmp_load);
            end
            if (pending) begin
                nxt = fix_target;
                pending = 1'b0;
            end else if (jmp_req) begin
                nxt = jmp_target;
            end else if (branch_req) begin
                fix_target = pc_m + {{8{branch_offset[7]}}, branch_offset};
                if (fix_target[15:8] == pc_m[15:8]) begin
                    nxt = fix_target;
                end else begin
                    nxt = {pc_m[15:8], fix_target[7:0]};
                    pending = 1'b1;
                end
            end else if (fetch_req) begin
                nxt = pc_m + 16'd1;
            end else begin
                nxt = pc_m;
            end
            tick();
            checks++;
            if ({pch, pcl_q} !== nxt) begin
                failures++;
                $display("FAIL rand_pc it=%0d pc=%h exp %h", i, {pch, pcl_q}, nxt);
            end
            pc_m = nxt;
        end
        clear_req();
        tick();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_branch();
        test_jmp_priority();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
